alu_operand_skid: RTL and testbench

//  ID/EX pipeline register feeding the alu: captures operands A/B, 4-bit aluControl and dest reg rd from decode.

---
 rtl/alu_operand_skid.sv | 149 ++++++++++++++
 tb/tb_alu_operand_skid.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_skid.sv
// ID/EX operand skid buffer: two-slot valid/ready register in front of the alu.
// Build option ALU_OPERAND_FWD_EN adds write-back forwarding into held operands.
module alu_operand_skid #(
  parameter int n  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_A,
  input  logic [n-1:0]  in_B,
  input  logic [3:0]    in_aluControl,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
`ifdef ALU_OPERAND_FWD_EN
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic [n-1:0]  wb_data,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  A,
  output logic [n-1:0]  B,
  output logic [3:0]    aluControl,
  output logic [RW-1:0] rd
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_t;

  typedef struct packed {
    logic [n-1:0]  a;
    logic [n-1:0]  b;
    logic [3:0]    op;
    logic [RW-1:0] rd;
`ifdef ALU_OPERAND_FWD_EN
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
`endif
  } pay_t;

  state_t state, state_nx;
  pay_t   out_q, skid_q, in_p;
  logic   in_fire, out_fire;
  logic   ld_in, ld_skid, skid_ld;

`ifdef ALU_OPERAND_FWD_EN
  assign in_p = '{a: in_A, b: in_B, op: in_aluControl,
                  rd: in_rd, rs1: in_rs1, rs2: in_rs2};

  // x0 never forwards: it is hardwired zero
  function automatic pay_t fwd(input pay_t p);
    pay_t r;
    r = p;
    if (wb_valid && wb_rd != '0) begin
      if (p.rs1 == wb_rd) r.a = wb_data;
      if (p.rs2 == wb_rd) r.b = wb_data;
    end
    return r;
  endfunction
`else
  assign in_p = '{a: in_A, b: in_B, op: in_aluControl, rd: in_rd};

  logic unused_rs;
  assign unused_rs = ^{in_rs1, in_rs2};

  function automatic pay_t fwd(input pay_t p);
    return p;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_in    = 1'b0;
    ld_skid  = 1'b0;
    skid_ld  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx = FULL;
          ld_in    = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          ld_in    = 1'b1;
        end else if (in_fire) begin
          state_nx = SKIDDED;
          skid_ld  = 1'b1;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      SKIDDED: begin
        if (out_fire) begin
          state_nx = FULL;
          ld_skid  = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) begin
      state_nx = EMPTY;
      ld_in    = 1'b0;
      ld_skid  = 1'b0;
      skid_ld  = 1'b0;
    end
  end

  // handshake flags come from the state flops only
  always_comb begin
    out_valid = (state != EMPTY);
    in_ready  = (state != SKIDDED);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      unique case (1'b1)
        ld_in:   out_q <= fwd(in_p);
        ld_skid: out_q <= fwd(skid_q);
        default: out_q <= fwd(out_q);
      endcase
      if (skid_ld) skid_q <= fwd(in_p);
      else         skid_q <= fwd(skid_q);
    end
  end

  assign A          = out_q.a;
  assign B          = out_q.b;
  assign aluControl = out_q.op;
  assign rd         = out_q.rd;

endmodule

// File: tb/tb_alu_operand_skid.sv
// Bench for alu_operand_skid: directed cases plus random traffic
// against a queue-based reference model.
module tb_alu_operand_skid;

  localparam int N  = 32;
  localparam int RW = 5;

  logic          clk, rst_n, flush;
  logic          in_valid, in_ready;
  logic [N-1:0]  in_A, in_B;
  logic [3:0]    in_aluControl;
  logic [RW-1:0] in_rd, in_rs1, in_rs2;
  logic          out_valid, out_ready;
  logic [N-1:0]  A, B;
  logic [3:0]    aluControl;
  logic [RW-1:0] rd;
`ifdef ALU_OPERAND_FWD_EN
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [N-1:0]  wb_data;
`endif

  alu_operand_skid #(.n(N), .RW(RW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_A(in_A),
    .in_B(in_B),
    .in_aluControl(in_aluControl),
    .in_rd(in_rd),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
`ifdef ALU_OPERAND_FWD_EN
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .A(A),
    .B(B),
    .aluControl(aluControl),
    .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [3:0]    op;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
  } op_t;

  op_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic op_t mfwd(input op_t o);
    op_t r;
    r = o;
`ifdef ALU_OPERAND_FWD_EN
    if (wb_valid && wb_rd != 0) begin
      if (o.rs1 == wb_rd) r.a = wb_data;
      if (o.rs2 == wb_rd) r.b = wb_data;
    end
`endif
    return r;
  endfunction

  // Reference: at most two ops outstanding, head is what execute sees
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit  fi, fo;
      op_t nw;
      fi = in_valid && (q.size() < 2);
      fo = out_ready && (q.size() > 0);
      nw = mfwd('{in_A, in_B, in_aluControl, in_rd, in_rs1, in_rs2});
      foreach (q[i]) q[i] = mfwd(q[i]);
      if (flush) begin
        q.delete();
      end else begin
        if (fo) void'(q.pop_front());
        if (fi) q.push_back(nw);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("A", A, q[0].a);
      chk("B", B, q[0].b);
      chk("aluControl", aluControl, q[0].op);
      chk("rd", rd, q[0].rd);
    end
  endtask

  task automatic put(input logic v, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic [3:0] op,
                     input logic [RW-1:0] d);
    in_valid      = v;
    in_A          = a;
    in_B          = b;
    in_aluControl = op;
    in_rd         = d;
    in_rs1        = RW'($urandom_range(0, 3));
    in_rs2        = RW'($urandom_range(0, 3));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    put(1'b0, '0, '0, 4'd0, '0);
`ifdef ALU_OPERAND_FWD_EN
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_op", aluControl, 0);
    chk("rst_rd", rd, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);

    // single op, next-cycle latency
    out_ready = 1'b1;
    put(1'b1, 5, 3, 4'b0000, 7);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_A", A, 5);
    chk("t1_B", B, 3);
    chk("t1_rd", rd, 7);
    chk("t1_ready", in_ready, 1);
    put(1'b0, '0, '0, 4'd0, '0);
    tick();

    // back-to-back stream
    for (int k = 1; k <= 20; k++) begin
      put(1'b1, N'(k), N'(k + 100), 4'(k % 13), RW'(k));
      tick();
      chk("t2_A", A, k);
      chk("t2_ready", in_ready, 1);
    end
    put(1'b0, '0, '0, 4'd0, '0);
    tick();

    // skid: X then Y with execute stalled
    out_ready = 1'b0;
    put(1'b1, 11, 1, 4'd2, 1);
    tick();
    put(1'b1, 22, 2, 4'd3, 2);
    tick();
    chk("t3_A_x", A, 11);
    chk("t3_ready0", in_ready, 0);
    put(1'b0, '0, '0, 4'd0, '0);
    out_ready = 1'b1;
    tick();
    chk("t3_A_y", A, 22);
    chk("t3_ready1", in_ready, 1);
    tick();

    // flush while skidded, with an op offered
    out_ready = 1'b0;
    put(1'b1, 33, 3, 4'd1, 3);
    tick();
    put(1'b1, 44, 4, 4'd1, 4);
    tick();
    put(1'b1, 55, 5, 4'd1, 5);
    flush = 1'b1;
    tick();
    chk("t4_valid", out_valid, 0);
    chk("t4_ready", in_ready, 1);
    flush = 1'b0;
    put(1'b0, '0, '0, 4'd0, '0);
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("t4_gone", out_valid, 0);
    end

    // async reset while skidded
    out_ready = 1'b0;
    put(1'b1, 66, 6, 4'd5, 6);
    tick();
    put(1'b1, 77, 7, 4'd6, 8);
    tick();
    put(1'b0, '0, '0, 4'd0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", out_valid, 0);
    chk("t5_ready", in_ready, 1);
    chk("t5_A", A, 0);
    chk("t5_B", B, 0);
    chk("t5_op", aluControl, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      if (!(in_valid && q.size() >= 2))
        put(($urandom % 4) != 0, $urandom, $urandom,
            4'($urandom_range(0, 12)), RW'($urandom));
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 20) == 0;
`ifdef ALU_OPERAND_FWD_EN
      wb_valid = ($urandom % 2) != 0;
      wb_rd    = RW'($urandom_range(0, 3));
      wb_data  = $urandom;
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
